posit_adder_arbiter: RTL and testbench

POSIT_ADDER_ARBITER -- requirements
Module: posit_adder_arbiter

---
 rtl/posit_adder_arbiter.sv | 127 ++++++++++++
 tb/tb_posit_adder_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_adder_arbiter.sv
// posit_adder_arbiter: shares one posit adder among N_REQ requesters and routes in-order results back by tag.
module posit_adder_arbiter #(
    parameter int N_REQ     = 4,
    parameter int OP_W      = 64,
    parameter int RES_W     = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_rts,
    output logic [N_REQ-1:0]             req_rtr,
    input  logic [N_REQ-1:0]             req_sow,
    input  logic [N_REQ-1:0]             req_eow,
    input  logic [N_REQ*OP_W-1:0]        req_data,
    output logic                         add_rts,
    input  logic                         add_rtr,
    output logic                         add_sow,
    output logic                         add_eow,
    output logic [OP_W-1:0]              add_data,
    input  logic                         res_rts,
    output logic                         res_rtr,
    input  logic [RES_W-1:0]             res_data,
    output logic [N_REQ-1:0]             out_rts,
    input  logic [N_REQ-1:0]             out_rtr,
    output logic [RES_W-1:0]             out_data,
    output logic [$clog2(TAG_DEPTH):0]   in_flight,
    output logic                         err
);
    localparam int SW = $clog2(N_REQ);
    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_gnt;
    logic [SW-1:0]   r_ptr;
    logic [SW-1:0]   r_tags [TAG_DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic [SW-1:0]   w_sel;
    logic [SW-1:0]   w_idx;
    logic [SW-1:0]   w_head;
    logic            w_valid;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    // Rotating-priority pick when idle; a locked window keeps its owner even while it stalls
    always_comb begin
        w_sel   = r_gnt;
        w_idx   = '0;
        w_valid = (r_state == LOCKED);
        if (r_state == IDLE) begin
            w_sel = r_ptr;
            for (int k = N_REQ - 1; k >= 0; k--) begin
                w_idx = SW'((int'(r_ptr) + k) % N_REQ);
                if (req_rts[w_idx]) begin
                    w_sel   = w_idx;
                    w_valid = 1'b1;
                end
            end
        end
    end

    assign w_full    = (r_cnt == CW'(TAG_DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign add_rts   = req_rts[w_sel] & ~w_full;
    assign add_sow   = req_sow[w_sel];
    assign add_eow   = req_eow[w_sel];
    assign add_data  = req_data[w_sel*OP_W +: OP_W];
    assign w_push    = add_rts & add_rtr;
    assign w_head    = r_tags[r_rd];
    assign res_rtr   = out_rtr[w_head] & ~w_empty;
    assign w_pop     = res_rts & res_rtr;
    assign out_data  = res_data;
    assign in_flight = r_cnt;
    assign err       = r_err;

    // One-hot handshake fan-out: operand ready to the selected requester, result valid to the head tag
    always_comb begin
        req_rtr         = '0;
        out_rts         = '0;
        req_rtr[w_sel]  = add_rtr & ~w_full & w_valid & rst_n;
        out_rts[w_head] = res_rts & ~w_empty;
    end

    // Window FSM: a non-final beat locks the grant, a final beat releases it and advances priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else if (w_push) begin
            if (add_eow) begin
                r_ptr   <= SW'((int'(w_sel) + 1) % N_REQ);
                r_state <= IDLE;
            end else if (r_state == IDLE) begin
                r_gnt   <= w_sel;
                r_state <= LOCKED;
            end
        end
    end

    // Tag FIFO bookkeeping and sticky error for a result arriving with nothing outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (res_rts & w_empty) r_err <= 1'b1;
        end
    end

    // Tag storage needs no reset: occupancy alone decides which entries are live
    always_ff @(posedge clk) begin
        if (w_push) r_tags[r_wr] <= w_sel;
    end
endmodule

// File: tb/tb_posit_adder_arbiter.sv
// tb_posit_adder_arbiter: directed scenarios plus randomized scoreboard run against a behavioural arbiter model.
module tb_posit_adder_arbiter;
    localparam int N  = 4;
    localparam int OW = 64;
    localparam int RW = 32;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_rts, req_rtr, req_sow, req_eow;
    logic [N*OW-1:0] req_data;
    logic            add_rts, add_rtr, add_sow, add_eow;
    logic [OW-1:0]   add_data;
    logic            res_rts, res_rtr;
    logic [RW-1:0]   res_data;
    logic [N-1:0]    out_rts, out_rtr;
    logic [RW-1:0]   out_data;
    logic [2:0]      in_flight;
    logic            err;

    posit_adder_arbiter #(.N_REQ(N), .OP_W(OW), .RES_W(RW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_rts(req_rts), .req_rtr(req_rtr), .req_sow(req_sow), .req_eow(req_eow), .req_data(req_data),
        .add_rts(add_rts), .add_rtr(add_rtr), .add_sow(add_sow), .add_eow(add_eow), .add_data(add_data),
        .res_rts(res_rts), .res_rtr(res_rtr), .res_data(res_data),
        .out_rts(out_rts), .out_rtr(out_rtr), .out_data(out_data),
        .in_flight(in_flight), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            req;
        logic [RW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [RW-1:0] pipe[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            n_mon = 0;
    bit            mon_en = 0;
    bit            auto_res = 0;

    function automatic logic [RW-1:0] f(input logic [OW-1:0] x);
        return x[31:0] ^ x[63:32] ^ 32'h3c5a_96e1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_res) res_rts = (in_flight != 0);
        #1;
    endtask

    task automatic drain();
        req_rts = '0;
        out_rtr = '1;
        for (int k = 0; k < 20 && in_flight != 0; k++) begin
            res_rts = 1'b1;
            step();
        end
        res_rts = 1'b0;
        #1;
        chk("drain_in_flight", in_flight, 0);
    endtask

    // Scoreboard monitor: every delivered result must match the oldest expected (requester, value)
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && (out_rts & out_rtr) != '0) begin
            if (exp_q.size() == 0) begin
                chk("mon_unexpected", out_rts & out_rtr, 0);
            end else begin
                e = exp_q.pop_front();
                n_mon++;
                chk("mon_dest", out_rts & out_rtr, oh(e.req));
                chk("mon_data", out_data, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit            m_locked;
        int            m_gnt, m_ptr, msel, hd;
        bit            any, full, ne, e_add, e_rr, xa, xr, se;
        bit [N-1:0]    mid;
        logic [N-1:0]  e_rtr, e_out;
        logic [OW-1:0] ad;
        req_rts = 4'b0001; req_sow = '0; req_eow = '0; req_data = '0;
        add_rtr = 1'b1; res_rts = 1'b0; res_data = '0; out_rtr = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_flight", in_flight, 0);
        chk("rst_err", err, 0);
        chk("rst_req_rtr", req_rtr, 0);
        chk("rst_res_rtr", res_rtr, 0);
        chk("rst_out_rts", out_rts, 0);
        chk("rst_add_rts", add_rts, 1);
        rst_n = 1'b1;
        req_rts = '1; req_sow = '1; req_eow = '1; out_rtr = '1; auto_res = 1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_grant%0d", k), req_rtr, oh(k % 4));
            step();
        end
        auto_res = 0;
        drain();
        auto_res = 1;
        req_rts = 4'b0010;
        #1;
        chk("win_pre", req_rtr, 4'b0010);
        step();
        req_rts = '1; req_sow = 4'b0100; req_eow = '0;
        #1;
        chk("win_beat0", req_rtr, 4'b0100);
        step();
        req_sow = '0;
        #1;
        chk("win_beat1", req_rtr, 4'b0100);
        step();
        req_eow = 4'b0100;
        #1;
        chk("win_beat2", req_rtr, 4'b0100);
        step();
        req_sow = '1; req_eow = '1;
        #1;
        chk("win_after", req_rtr, 4'b1000);
        step();
        auto_res = 0;
        drain();
        res_rts = 1'b0; req_rts = 4'b0001;
        repeat (4) step();
        chk("full_in_flight", in_flight, 4);
        chk("full_add_rts", add_rts, 0);
        chk("full_req_rtr", req_rtr, 0);
        res_rts = 1'b1;
        #1;
        chk("full_pop_res_rtr", res_rtr, 1);
        chk("full_pop_add_rts", add_rts, 0);
        step();
        res_rts = 1'b0;
        #1;
        chk("after_pop_in_flight", in_flight, 3);
        chk("after_pop_add_rts", add_rts, 1);
        step();
        chk("refill_in_flight", in_flight, 4);
        drain();
        out_rtr = '0;
        req_rts = 4'b0010; step();
        req_rts = 4'b1000; step();
        req_rts = 4'b0001; step();
        req_rts = '0;
        #1;
        chk("order_in_flight", in_flight, 3);
        res_rts = 1'b1; res_data = 32'ha1; out_rtr = 4'b1101;
        #1;
        chk("hold_res_rtr", res_rtr, 0);
        chk("hold_out_rts", out_rts, 4'b0010);
        chk("hold_out_data", out_data, 32'ha1);
        step();
        chk("hold_in_flight", in_flight, 3);
        out_rtr = '1;
        #1;
        chk("order_first", out_rts, 4'b0010);
        chk("order_res_rtr", res_rtr, 1);
        step();
        res_data = 32'hb2;
        #1;
        chk("order_second", out_rts, 4'b1000);
        step();
        res_data = 32'hc3;
        #1;
        chk("order_third", out_rts, 4'b0001);
        step();
        res_rts = 1'b0;
        #1;
        chk("order_empty", in_flight, 0);
        res_rts = 1'b1;
        #1;
        chk("err_before", err, 0);
        chk("err_res_rtr", res_rtr, 0);
        chk("err_out_rts", out_rts, 0);
        step();
        chk("err_set", err, 1);
        res_rts = 1'b0;
        step();
        step();
        chk("err_sticky", err, 1);
        req_rts = 4'b0100; req_sow = 4'b0100; req_eow = '0; out_rtr = '0;
        step();
        req_sow = '0;
        step();
        chk("lock_in_flight", in_flight, 2);
        req_rts = '1;
        #1;
        chk("lock_grant", req_rtr, 4'b0100);
        #1;
        rst_n = 1'b0; res_rts = 1'b1;
        #1;
        chk("arst_in_flight", in_flight, 0);
        chk("arst_err", err, 0);
        chk("arst_req_rtr", req_rtr, 0);
        chk("arst_out_rts", out_rts, 0);
        chk("arst_res_rtr", res_rtr, 0);
        step();
        res_rts = 1'b0; req_sow = '1; req_eow = '1; rst_n = 1'b1;
        #1;
        chk("arst_idle_ptr0", req_rtr, 4'b0001);
        rst_n = 1'b0; req_rts = '0;
        #2;
        rst_n = 1'b1;
        m_locked = 0; m_gnt = 0; m_ptr = 0; mid = '0;
        mon_en = 1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                req_rts[i] = ($urandom_range(0, 3) != 0);
                req_sow[i] = !mid[i];
                req_eow[i] = ($urandom_range(0, 2) == 0);
                req_data[i*OW +: OW] = {$urandom, $urandom};
                out_rtr[i] = ($urandom_range(0, 2) != 0);
            end
            add_rtr = ($urandom_range(0, 4) != 0);
            res_rts = (pipe.size() > 0) && ($urandom_range(0, 3) != 0);
            res_data = (pipe.size() > 0) ? pipe[0] : $urandom;
            #1;
            any = 0;
            msel = m_ptr;
            if (m_locked) begin
                msel = m_gnt;
                any = 1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!any && req_rts[(m_ptr + k) % N]) begin
                        msel = (m_ptr + k) % N;
                        any = 1;
                    end
                end
            end
            full  = (pipe.size() >= TD);
            ne    = (pipe.size() > 0);
            hd    = (exp_q.size() > 0) ? exp_q[0].req : 0;
            e_add = any && req_rts[msel] && !full;
            e_rtr = (any && add_rtr && !full) ? oh(msel) : '0;
            e_rr  = ne && out_rtr[hd];
            e_out = (res_rts && ne) ? oh(hd) : '0;
            chk("rnd_add_rts", add_rts, e_add);
            chk("rnd_req_rtr", req_rtr, e_rtr);
            chk("rnd_in_flight", in_flight, pipe.size());
            chk("rnd_res_rtr", res_rtr, e_rr);
            chk("rnd_out_rts", out_rts, e_out);
            chk("rnd_err", err, 0);
            if (e_add) begin
                chk("rnd_add_data", add_data, req_data[msel*OW +: OW]);
                chk("rnd_add_sow", add_sow, req_sow[msel]);
                chk("rnd_add_eow", add_eow, req_eow[msel]);
            end
            xa = e_add && add_rtr;
            xr = res_rts && e_rr;
            ad = add_data;
            se = req_eow[msel];
            @(posedge clk);
            if (xa) begin
                exp_q.push_back('{msel, f(req_data[msel*OW +: OW])});
                pipe.push_back(f(ad));
                mid[msel] = !se;
                if (se) begin
                    m_ptr = (msel + 1) % N;
                    m_locked = 0;
                end else if (!m_locked) begin
                    m_locked = 1;
                    m_gnt = msel;
                end
            end
            if (xr) void'(pipe.pop_front());
            #1;
        end
        req_rts = '0;
        out_rtr = '1;
        for (int k = 0; k < 20 && pipe.size() > 0; k++) begin
            res_rts = 1'b1;
            res_data = pipe[0];
            @(posedge clk);
            void'(pipe.pop_front());
            #1;
        end
        res_rts = 1'b0;
        @(negedge clk);
        chk("end_scoreboard_empty", exp_q.size(), 0);
        chk("end_in_flight", in_flight, 0);
        chk("end_results_seen", n_mon > 100, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
